// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared state encoding and sizing constants for the serial program loader
package uart_loader_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, ACK} state_t;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'h57;
  localparam int BCNT_W = 2;
  localparam int TIMEOUT_DEF = 250000;

  function automatic int tmo_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/uart_loader.sv
// uart_loader: receives a framed byte stream, writes little-endian words onto the dev bus, replies with an XOR checksum
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        devEnable_o,
  output logic        devWrite_o,
  input  logic        devBusy_i,
  output logic [31:0] devPhysicalAddr_o,
  output logic [31:0] devDataSave_o,
  output logic [3:0]  devByteSelect_o,
  output logic        active_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int TW = tmo_w(TIMEOUT_CYCLES);

  state_t state, state_nx;
  logic [31:0] addr, wdata;
  logic [15:0] len;
  logic [7:0] chk, buf_data;
  logic buf_full, err;
  logic [BCNT_W-1:0] bcnt;
  logic [TW-1:0] tmo;
  logic in_rx, take, hdr, overrun, tmo_hit, abort, wr_done, ack_go;

  // Decode buffer/abort events and choose the next frame state.
  always_comb begin
    in_rx = state inside {ADDR, LEN, DATA};
    take = buf_full && (in_rx || state == IDLE);
    hdr = state == IDLE && take && buf_data == HEADER_BYTE;
    overrun = rxdReady_i && buf_full && state != IDLE && !take;
    tmo_hit = in_rx && tmo == TW'(TIMEOUT_CYCLES);
    abort = overrun || tmo_hit;
    wr_done = state == WRITE && !devBusy_i;
    ack_go = state == ACK && !txdBusy_i && !overrun;
    state_nx = state;
    if (abort) state_nx = IDLE;
    else
      case (state)
        IDLE:  if (hdr) state_nx = ADDR;
        ADDR:  if (take && bcnt == BCNT_W'(3)) state_nx = LEN;
        LEN:   if (take && bcnt == BCNT_W'(1)) state_nx = {buf_data, len[15:8]} == 16'd0 ? ACK : DATA;
        DATA:  if (take && bcnt == BCNT_W'(3)) state_nx = WRITE;
        WRITE: if (wr_done) state_nx = len == 16'd1 ? ACK : DATA;
        ACK:   if (ack_go) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end

  // Frame state register; reset pulls the bus off immediately.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // Byte buffer, inter-byte timeout, sticky error and the address/length/data shifters.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      tmo <= '0;
      err <= 1'b0;
      addr <= '0;
      len <= '0;
      chk <= '0;
      bcnt <= '0;
      wdata <= '0;
    end else begin
      buf_full <= abort ? 1'b0 : rxdReady_i ? 1'b1 : take ? 1'b0 : buf_full;
      if (rxdReady_i) buf_data <= rxdData_i;
      tmo <= (rxdReady_i || !in_rx || abort) ? '0 : buf_full ? tmo : tmo + TW'(1);
      err <= abort ? 1'b1 : hdr ? 1'b0 : err;
      if (hdr) begin
        addr <= '0;
        len <= '0;
        chk <= '0;
        bcnt <= '0;
      end else if (take && in_rx && !abort) begin
        chk <= chk ^ buf_data;
        bcnt <= (state == LEN && bcnt == BCNT_W'(1)) ? '0 : bcnt + BCNT_W'(1);
        if (state == ADDR) addr <= bcnt == BCNT_W'(3) ? {buf_data, addr[31:10], 2'b00} : {buf_data, addr[31:8]};
        if (state == LEN) len <= {buf_data, len[15:8]};
        if (state == DATA) wdata <= {buf_data, wdata[31:8]};
      end else if (wr_done && !abort) begin
        addr <= addr + 32'd4;
        len <= len - 16'd1;
      end
    end

  assign active_o = state != IDLE;
  assign devEnable_o = state == WRITE;
  assign devWrite_o = devEnable_o;
  assign devByteSelect_o = {4{devEnable_o}};
  assign devPhysicalAddr_o = addr;
  assign devDataSave_o = wdata;
  assign txdStart_o = ack_go;
  assign done_o = ack_go;
  assign txdData_o = chk;
  assign err_o = err;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: table-driven frames with write/checksum scoreboards plus abort and reset sequences
module tb_uart_loader;

  logic clk, rst_n, rxdReady_i, txdBusy_i, devBusy_i;
  logic [7:0] rxdData_i, txdData_o;
  logic txdStart_o, devEnable_o, devWrite_o, active_o, done_o, err_o;
  logic [31:0] devPhysicalAddr_o, devDataSave_o;
  logic [3:0] devByteSelect_o;

  uart_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rxdReady_i(rxdReady_i),
    .rxdData_i(rxdData_i),
    .txdBusy_i(txdBusy_i),
    .txdStart_o(txdStart_o),
    .txdData_o(txdData_o),
    .devEnable_o(devEnable_o),
    .devWrite_o(devWrite_o),
    .devBusy_i(devBusy_i),
    .devPhysicalAddr_o(devPhysicalAddr_o),
    .devDataSave_o(devDataSave_o),
    .devByteSelect_o(devByteSelect_o),
    .active_o(active_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic [1:0][31:0] data;
    logic [7:0] busy;
    logic [7:0] txhold;
    logic [7:0] chk;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  vec_t tbl [5];
  wr_t wq [$];
  logic [7:0] cq [$];
  int errors = 0, checks = 0, done_seen = 0, stall = 0, cyc = 0, exp_busy = 0;
  logic force_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Device model: busy for exp_busy cycles of each write, or indefinitely when forced.
  always @(posedge clk) begin
    #1;
    cyc = devEnable_o ? cyc + 1 : 0;
    devBusy_i = force_busy || (devEnable_o && cyc <= exp_busy);
  end

  // Scoreboard: bus completions and transmitted checksum bytes.
  always @(negedge clk) if (rst_n) begin
    if (!devEnable_o) stall = 0;
    else if (devBusy_i) stall++;
    else begin
      if (wq.size() == 0) flag("unexpected_write");
      else begin
        wr_t e;
        e = wq.pop_front();
        check("wr_addr", devPhysicalAddr_o, e.a);
        check("wr_data", devDataSave_o, e.d);
        check("wr_bsel", {28'd0, devByteSelect_o}, 32'hf);
        check("wr_strobe", {31'd0, devWrite_o}, 32'd1);
        check("wr_stall", stall, exp_busy);
      end
      stall = 0;
    end
    if (txdStart_o) begin
      if (txdBusy_i) flag("txd_while_busy");
      if (cq.size() == 0) flag("unexpected_txd");
      else check("txd_chk", {24'd0, txdData_o}, {24'd0, cq.pop_front()});
    end
    if (txdStart_o || done_o) check("done_with_txd", {31'd0, done_o}, {31'd0, txdStart_o});
    if (done_o) done_seen++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rxdReady_i = 1'b1;
    rxdData_i = b;
    @(posedge clk); #1;
    rxdReady_i = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!active_o) return;
    end
    flag(name);
  endtask

  task automatic run_frame(input vec_t v);
    logic [31:0] a;
    int d0;
    exp_busy = v.busy;
    txdBusy_i = v.txhold != 0;
    a = {v.addr[31:2], 2'b00};
    for (int i = 0; i < v.len; i++) begin
      wq.push_back({a, v.data[i]});
      a = a + 32'd4;
    end
    cq.push_back(v.chk);
    d0 = done_seen;
    send_byte(8'h57, 8);
    check("err_cleared_by_header", {31'd0, err_o}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8], 8);
    send_byte(v.len[7:0], 8);
    send_byte(v.len[15:8], 8);
    for (int i = 0; i < v.len; i++)
      for (int j = 0; j < 4; j++) send_byte(v.data[i][8*j +: 8], 8);
    if (v.txhold != 0) begin
      repeat (v.txhold) @(posedge clk);
      #1;
      check("ack_waits_txd_busy", {31'd0, active_o}, 32'd1);
      txdBusy_i = 1'b0;
    end
    wait_idle("frame_end_timeout");
    check("done_count", done_seen - d0, 32'd1);
    check("frame_err", {31'd0, err_o}, 32'd0);
    check("writes_drained", wq.size(), 32'd0);
    check("txd_drained", cq.size(), 32'd0);
  endtask

  task automatic enter_write(input logic [31:0] addr, input logic [31:0] data);
    force_busy = 1'b1;
    send_byte(8'h57, 8);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 8);
    send_byte(8'h01, 8);
    send_byte(8'h00, 8);
    for (int j = 0; j < 4; j++) send_byte(data[8*j +: 8], 8);
    @(negedge clk);
    check("write_held", {31'd0, devEnable_o}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tbl[0] = '{32'h80000000, 16'd1, {32'h0, 32'h12345678}, 8'd0, 8'd0, 8'h89};
    tbl[1] = '{32'h80000010, 16'd2, {32'h55667788, 32'h11223344}, 8'd3, 8'd0, 8'h1a};
    tbl[2] = '{32'h80000000, 16'd0, {32'h0, 32'h0}, 8'd0, 8'd0, 8'h80};
    tbl[3] = '{32'hfffffffc, 16'd2, {32'hcafef00d, 32'hdeadbeef}, 8'd1, 8'd5, 8'hea};
    tbl[4] = '{32'h00000103, 16'd1, {32'h0, 32'ha5a55a5a}, 8'd0, 8'd0, 8'h03};
    rst_n = 1'b0;
    rxdReady_i = 1'b0;
    rxdData_i = 8'h00;
    txdBusy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", {31'd0, active_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_txd_start", {31'd0, txdStart_o}, 32'd0);
    check("rst_txd_data", {24'd0, txdData_o}, 32'd0);
    check("rst_dev_en", {31'd0, devEnable_o}, 32'd0);
    check("rst_bsel", {28'd0, devByteSelect_o}, 32'd0);
    check("rst_addr", devPhysicalAddr_o, 32'd0);
    check("rst_wdata", devDataSave_o, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_frame(tbl[k]);

    // Inter-byte silence mid-address aborts with an error and no reply.
    d0 = done_seen;
    send_byte(8'h57, 8);
    send_byte(8'h11, 8);
    send_byte(8'h22, 0);
    repeat (80) @(posedge clk);
    #1;
    check("tmo_not_yet_active", {31'd0, active_o}, 32'd1);
    check("tmo_not_yet_err", {31'd0, err_o}, 32'd0);
    wait_idle("tmo_never_fired");
    check("tmo_err", {31'd0, err_o}, 32'd1);
    check("tmo_no_done", done_seen - d0, 32'd0);
    run_frame(tbl[0]);

    // Two bytes arriving while the device stalls a write overrun the buffer.
    enter_write(32'h00000040, 32'h01020304);
    send_byte(8'haa, 8);
    @(negedge clk);
    check("ovr_first_byte_err", {31'd0, err_o}, 32'd0);
    check("ovr_first_byte_en", {31'd0, devEnable_o}, 32'd1);
    send_byte(8'hbb, 0);
    @(negedge clk);
    check("ovr_en_dropped", {31'd0, devEnable_o}, 32'd0);
    check("ovr_err", {31'd0, err_o}, 32'd1);
    check("ovr_idle", {31'd0, active_o}, 32'd0);
    force_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("ovr_no_retry", {31'd0, devEnable_o}, 32'd0);
    run_frame(tbl[2]);

    // Asynchronous reset in the middle of a stalled write.
    enter_write(32'h00000080, 32'hcafebabe);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dev_en", {31'd0, devEnable_o}, 32'd0);
    check("arst_bsel", {28'd0, devByteSelect_o}, 32'd0);
    check("arst_active", {31'd0, active_o}, 32'd0);
    check("arst_txd_start", {31'd0, txdStart_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_busy = 1'b0;
    d0 = done_seen;
    send_byte(8'h00, 20);
    @(negedge clk);
    check("stray_active", {31'd0, active_o}, 32'd0);
    check("stray_err", {31'd0, err_o}, 32'd0);
    check("stray_no_done", done_seen - d0, 32'd0);
    run_frame(tbl[1]);

    check("final_writes_drained", wq.size(), 32'd0);
    check("final_txd_drained", cq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
